uart_serializer: RTL and testbench

UART_SERIALIZER -- requirements
Module: uart_serializer

---
 rtl/uart_serializer.sv | 168 ++++++++++++++++
 tb/tb_uart_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_serializer.sv
// uart_serializer
// ---------------
// Purpose: serialises one DataWidth-bit payload per frame onto an idle-high
// UART line. A frame is one start bit (0), the payload LSB first, an optional
// even-parity bit and one stop bit (1). Every bit is held for exactly
// B = 8*Prescale clock cycles, and a Prescale of 0 is treated as 1.
//
// Optional feature: define the macro UART_TX_PARITY_EN to insert an even
// parity bit (XOR of all payload bits) between the last data bit and the stop
// bit. When the macro is undefined, no parity state or logic is built.
//
// Ports:
//   clk_i      in   1          single clock, all logic on the rising edge
//   reset_i    in   1          synchronous active-high reset
//   data_i     in   DataWidth  payload, sampled only on the handshake edge
//   valid_i    in   1          data_i is offered
//   ready_o    out  1          a payload can be accepted this cycle
//   tx_data_o  out  1          registered serial line, idle high
//   busy_o     out  1          a frame is in progress
module uart_serializer #(
  parameter int unsigned DataWidth = 8,
  parameter logic [15:0] Prescale  = 16'd27
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_data_o,
  output logic                 busy_o
);

  // A Prescale of zero is promoted to one, so the shortest bit is 8 cycles.
  localparam int unsigned EffPrescale = (Prescale == 16'd0) ? 1 : int'(Prescale);
  localparam int unsigned BitCycles   = 8 * EffPrescale;
  localparam int          CntW        = $clog2(BitCycles);
  localparam logic [CntW-1:0] BitLast = CntW'(BitCycles - 1);

  localparam int BitIdxW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [BitIdxW-1:0] LastIdx = BitIdxW'(DataWidth - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;
`endif

  txState_t             r_state;
  logic [CntW-1:0]      r_baudCnt;
  logic [BitIdxW-1:0]   r_bitIdx;
  logic [DataWidth-1:0] r_shift;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  // Single registered state machine. The baud counter is reloaded to B-1 at
  // every bit boundary and the bit changes when it reaches zero, so each bit
  // lasts exactly B cycles with no accumulated drift. The shift register
  // always presents the next bit to send at position 0, so tx_data_o is only
  // ever loaded from registered state, never from data_i.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (valid_i && r_ready) begin
            r_shift   <= data_i;
            r_baudCnt <= BitLast;
            r_bitIdx  <= '0;
            r_tx      <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^data_i;
`endif
            r_state   <= START;
          end
        end

        START: begin
          if (r_baudCnt == '0) begin
            r_baudCnt <= BitLast;
            r_bitIdx  <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_state   <= DATA;
          end else begin
            r_baudCnt <= r_baudCnt - CntW'(1);
          end
        end

        DATA: begin
          if (r_baudCnt == '0) begin
            r_baudCnt <= BitLast;
            if (r_bitIdx == LastIdx) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_bitIdx <= r_bitIdx + BitIdxW'(1);
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
            end
          end else begin
            r_baudCnt <= r_baudCnt - CntW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (r_baudCnt == '0) begin
            r_baudCnt <= BitLast;
            r_tx      <= 1'b1;
            r_state   <= STOP;
          end else begin
            r_baudCnt <= r_baudCnt - CntW'(1);
          end
        end
`endif

        // Ready rises on the edge that ends the stop bit, so a held valid_i
        // is accepted one cycle later, leaving a single idle-high cycle.
        STOP: begin
          if (r_baudCnt == '0) begin
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_baudCnt <= r_baudCnt - CntW'(1);
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_data_o = r_tx;
  assign ready_o   = r_ready;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_uart_serializer.sv
// tb_uart_serializer
// ------------------
// Purpose: self-checking bench for uart_serializer. Two instances are used:
// dutA with Prescale=2 (B=16 cycles per bit) and dutB with Prescale=0, which
// must behave as Prescale=1 (B=8 cycles per bit). Expected frame bits are
// pushed to a queue at each handshake; the observed bits, one per bit period
// (X when the line was not stable for the whole period), are collected into
// a second queue and each test compares the two.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_serializer;

  localparam int BitA = 16;
  localparam int BitB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       validA, validB;
  logic [7:0] dataA, dataB;
  logic       readyA, txA, busyA;
  logic       readyB, txB, busyB;

  int checks = 0;
  int passed = 0;
  int statusErr = 0;

  logic expQ[$];
  logic obsQ[$];

  uart_serializer #(.DataWidth(8), .Prescale(16'd2)) dutA (
    .clk_i    (clk),
    .reset_i  (reset),
    .data_i   (dataA),
    .valid_i  (validA),
    .ready_o  (readyA),
    .tx_data_o(txA),
    .busy_o   (busyA)
  );

  uart_serializer #(.DataWidth(8), .Prescale(16'd0)) dutB (
    .clk_i    (clk),
    .reset_i  (reset),
    .data_i   (dataB),
    .valid_i  (validB),
    .ready_o  (readyB),
    .tx_data_o(txB),
    .busy_o   (busyB)
  );

  always #5 clk = ~clk;

  // Hard stop in case a test wedges somewhere unexpected.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Expected line levels for one frame: start, data LSB first, parity, stop.
  task automatic pushFrame(input logic [7:0] d);
    expQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) expQ.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    expQ.push_back(^d);
`endif
    expQ.push_back(1'b1);
  endtask

  // Offer d and return right after the accepting edge k; the frame is pushed
  // to the scoreboard at that moment.
  task automatic applyStimulus(input bit sel, input logic [7:0] d, input bit hold);
    int waited = 0;
    @(negedge clk);
    if (sel) begin dataB = d; validB = 1'b1; end
    else     begin dataA = d; validA = 1'b1; end
    while (((sel ? readyB : readyA) !== 1'b1) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 2000) begin
      checks++;
      $display("[TB] FAIL handshake_timeout ready=%b required=1", sel ? readyB : readyA);
    end
    @(posedge clk);
    pushFrame(d);
    if (!hold) begin
      #1;
      if (sel) validB = 1'b0; else validA = 1'b0;
    end
  endtask

  // Collect nBits bit periods starting with the cycle after the accepting
  // edge; also note any cycle where ready/busy disagree with a frame running.
  task automatic captureBits(input bit sel, input int nBits, input int bitLen);
    for (int i = 0; i < nBits; i++) begin
      logic first;
      logic v;
      bit   stable;
      first  = 1'bx;
      stable = 1'b1;
      for (int c = 0; c < bitLen; c++) begin
        @(negedge clk);
        v = sel ? txB : txA;
        if (c == 0) first = v;
        else if (v !== first) stable = 1'b0;
        if ((sel ? readyB : readyA) !== 1'b0 || (sel ? busyB : busyA) !== 1'b1)
          statusErr++;
      end
      obsQ.push_back(stable ? first : 1'bx);
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    validA = 1'b0; validB = 1'b0;
    dataA  = 8'h00; dataB = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (txA !== 1'b1)    $display("[TB] FAIL reset_txA got=%b exp=1", txA);    else passed++;
    checks++; if (readyA !== 1'b1) $display("[TB] FAIL reset_readyA got=%b exp=1", readyA); else passed++;
    checks++; if (busyA !== 1'b0)  $display("[TB] FAIL reset_busyA got=%b exp=0", busyA);  else passed++;
    checks++; if (txB !== 1'b1)    $display("[TB] FAIL reset_txB got=%b exp=1", txB);    else passed++;
    checks++; if (readyB !== 1'b1) $display("[TB] FAIL reset_readyB got=%b exp=1", readyB); else passed++;
    checks++; if (busyB !== 1'b0)  $display("[TB] FAIL reset_busyB got=%b exp=0", busyB);  else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One frame on dutA (B=16); ready must be back one cycle after the frame.
  task automatic test_frame(input logic [7:0] d);
    int idx = 0;
    logic e, o;
    statusErr = 0;
    applyStimulus(1'b0, d, 1'b0);
    captureBits(1'b0, FrameBits, BitA);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = (obsQ.size() > 0) ? obsQ.pop_front() : 1'bz;
      checks++;
      if (o !== e) $display("[TB] FAIL frame_%h bit%0d got=%b exp=%b", d, idx, o, e);
      else passed++;
      idx++;
    end
    obsQ.delete();
    checks++;
    if (statusErr !== 0) $display("[TB] FAIL frame_%h_status got=%0d exp=0", d, statusErr);
    else passed++;
    @(negedge clk);
    checks++;
    if (readyA !== 1'b1 || busyA !== 1'b0 || txA !== 1'b1)
      $display("[TB] FAIL frame_%h_end ready/busy/tx got=%b%b%b exp=101", d, readyA, busyA, txA);
    else passed++;
  endtask

  // New data and valid pulses during a frame must not disturb it.
  task automatic test_ignore_during_frame;
    int idx = 0;
    int extra = 0;
    logic e, o;
    statusErr = 0;
    applyStimulus(1'b0, 8'h3C, 1'b0);
    fork
      captureBits(1'b0, FrameBits, BitA);
      begin
        repeat (5) begin
          repeat (23) @(negedge clk);
          dataA  = 8'($urandom);
          validA = 1'b1;
          @(negedge clk);
          validA = 1'b0;
        end
      end
    join
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = (obsQ.size() > 0) ? obsQ.pop_front() : 1'bz;
      checks++;
      if (o !== e) $display("[TB] FAIL ignore bit%0d got=%b exp=%b", idx, o, e);
      else passed++;
      idx++;
    end
    obsQ.delete();
    checks++;
    if (statusErr !== 0) $display("[TB] FAIL ignore_status got=%0d exp=0", statusErr);
    else passed++;
    repeat (3 * BitA) begin
      @(negedge clk);
      if (txA !== 1'b1 || busyA !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) $display("[TB] FAIL ignore_no_extra_frame got=%0d exp=0", extra);
    else passed++;
  endtask

  // Reset sampled at edge k+40 abandons the frame; valid is still high on
  // that edge and must not be accepted.
  task automatic test_reset_mid_frame;
    int stray = 0;
    applyStimulus(1'b0, 8'hF0, 1'b1);
    expQ.delete();
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (txA !== 1'b1 || readyA !== 1'b1 || busyA !== 1'b0)
      $display("[TB] FAIL midreset tx/ready/busy got=%b%b%b exp=110", txA, readyA, busyA);
    else passed++;
    reset  = 1'b0;
    validA = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (txA !== 1'b1 || busyA !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) $display("[TB] FAIL midreset_no_retransmit got=%0d exp=0", stray);
    else passed++;
    test_frame(8'hC3);
  endtask

  // dutB (Prescale=0, so B=8) with valid held: two frames separated by one
  // idle-high cycle, then nothing more.
  task automatic test_back_to_back;
    int idx = 0;
    int extra = 0;
    logic e, o;
    statusErr = 0;
    applyStimulus(1'b1, 8'h55, 1'b1);
    captureBits(1'b1, FrameBits, BitB);
    @(negedge clk);
    checks++;
    if (readyB !== 1'b1 || txB !== 1'b1)
      $display("[TB] FAIL b2b_gap ready/tx got=%b%b exp=11", readyB, txB);
    else passed++;
    dataB = 8'h0F;
    @(posedge clk);
    pushFrame(8'h0F);
    #1 validB = 1'b0;
    captureBits(1'b1, FrameBits, BitB);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = (obsQ.size() > 0) ? obsQ.pop_front() : 1'bz;
      checks++;
      if (o !== e) $display("[TB] FAIL b2b bit%0d got=%b exp=%b", idx, o, e);
      else passed++;
      idx++;
    end
    obsQ.delete();
    checks++;
    if (statusErr !== 0) $display("[TB] FAIL b2b_status got=%0d exp=0", statusErr);
    else passed++;
    repeat (3 * BitB) begin
      @(negedge clk);
      if (txB !== 1'b1 || busyB !== 1'b0 || readyB !== 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) $display("[TB] FAIL b2b_no_duplicate got=%0d exp=0", extra);
    else passed++;
  endtask

  initial begin
    $display("[TB] uart_serializer bench start");
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h07);
    test_ignore_during_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
